dsp48a1_mac_sequencer: RTL and testbench

//  Upstream control stage for one Spartan6_DSP48A1 slice used as an unsigned multiply-accumulator.

---
 rtl/dsp48a1_mac_sequencer.sv | 135 +++++++++++++
 tb/tb_dsp48a1_mac_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp48a1_mac_sequencer.sv
// Control stage that streams operand pairs into a DSP48A1 multiply-accumulate slice,
// steers its OPMODE per tap and returns one accumulated dot product per frame.
module dsp48a1_mac_sequencer #(
  parameter int N_TAPS  = 8,
  parameter int OPM_DLY = 2,
  parameter int P_LAT   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_a,
  input  logic [17:0] in_b,
  output logic [17:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [7:0]  dsp_opmode,
  output logic        dsp_rst,
  input  logic [47:0] dsp_p,
  input  logic        dsp_carryout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [47:0] res_data,
  output logic        res_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD_RES} state_t;

  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_HOLD  = 8'h08;

  localparam int TW = (N_TAPS > 2) ? $clog2(N_TAPS) : 1;
  localparam logic [TW-1:0] LAST_TAP = TW'(N_TAPS - 1);
  localparam int DW = $clog2(P_LAT + 1);
  localparam logic [DW-1:0] DRN_END = DW'(P_LAT);

  state_t          state, state_nxt;
  logic [TW-1:0]   tap_cnt;
  logic [DW-1:0]   drn_cnt;
  logic            issue;
  logic            capture;
  logic            landed;
  logic [7:0]      tag;
  logic [7:0]      opm_dly [OPM_DLY];
  logic [P_LAT:0]  land_vld;
  logic            ovf_sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    capture   = 1'b0;
    tag       = OPM_HOLD;
    case (state)
      IDLE: begin
        // Hold off the first operand until the slice has left reset.
        in_ready = !dsp_rst;
        if (in_valid && !dsp_rst) begin
          tag       = OPM_FIRST;
          state_nxt = (N_TAPS == 1) ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tag = OPM_ACC;
          if (tap_cnt == LAST_TAP) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drn_cnt == DRN_END) begin
          capture   = 1'b1;
          state_nxt = HOLD_RES;
        end
      end
      HOLD_RES: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign issue      = in_valid & in_ready;
  assign landed     = land_vld[P_LAT];
  assign dsp_opmode = opm_dly[OPM_DLY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsp_rst    <= 1'b1;
      dsp_a      <= '0;
      dsp_b      <= '0;
      tap_cnt    <= '0;
      drn_cnt    <= '0;
      land_vld   <= '0;
      ovf_sticky <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_ovf    <= 1'b0;
      for (int i = 0; i < OPM_DLY; i++) opm_dly[i] <= OPM_HOLD;
    end else begin
      dsp_rst <= 1'b0;

      // issue stage: operands to slice A/B, tag enters the OPMODE delay line
      opm_dly[0] <= tag;
      for (int i = 1; i < OPM_DLY; i++) opm_dly[i] <= opm_dly[i-1];
      land_vld <= {land_vld[P_LAT-1:0], issue && (state == ACCUM)};
      if (issue) begin
        dsp_a   <= in_a;
        dsp_b   <= in_b;
        tap_cnt <= (state == IDLE) ? TW'(1) : tap_cnt + 1'b1;
      end

      // P stage: a tap's carry-out is visible once its P update has landed
      if (issue && (state == IDLE)) ovf_sticky <= 1'b0;
      else if (landed)              ovf_sticky <= ovf_sticky | dsp_carryout;

      if (state != DRAIN) drn_cnt <= '0;
      else                drn_cnt <= drn_cnt + 1'b1;

      // result stage
      if (capture) begin
        res_data  <= dsp_p;
        res_ovf   <= ovf_sticky | (landed & dsp_carryout);
        res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench for dsp48a1_mac_sequencer: three instances (4, 1 and 4097 taps), each closed
// through a behavioural DSP48A1 slice, checked against a plain-arithmetic dot product.
module tb_dsp48a1_mac_sequencer;

  localparam int NI = 3;
  localparam logic [17:0] MAXV = 18'h3FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid     [NI];
  logic        in_ready     [NI];
  logic [17:0] in_a         [NI];
  logic [17:0] in_b         [NI];
  logic [17:0] dsp_a        [NI];
  logic [17:0] dsp_b        [NI];
  logic [7:0]  dsp_opmode   [NI];
  logic        dsp_rst      [NI];
  logic [47:0] dsp_p        [NI];
  logic        dsp_carryout [NI];
  logic        res_valid    [NI];
  logic        res_ready    [NI];
  logic [47:0] res_data     [NI];
  logic        res_ovf      [NI];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [48:0] slice_post(logic [7:0] op, logic [47:0] pv, logic [35:0] mv);
    logic [47:0] x, z;
    x = (op[1:0] == 2'b01) ? {12'd0, mv} : 48'd0;
    z = (op[3:2] == 2'b10) ? pv : 48'd0;
    return {1'b0, z} + {1'b0, x};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NTAP = (g == 0) ? 4 : ((g == 1) ? 1 : 4097);
    logic [17:0] a1, b1;
    logic [35:0] m;
    logic [7:0]  opm_r;
    logic [47:0] p;
    logic        co;

    dsp48a1_mac_sequencer #(.N_TAPS(NTAP), .OPM_DLY(2), .P_LAT(3)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_a(in_a[g]), .in_b(in_b[g]),
      .dsp_a(dsp_a[g]), .dsp_b(dsp_b[g]), .dsp_opmode(dsp_opmode[g]), .dsp_rst(dsp_rst[g]),
      .dsp_p(dsp_p[g]), .dsp_carryout(dsp_carryout[g]),
      .res_valid(res_valid[g]), .res_ready(res_ready[g]), .res_data(res_data[g]), .res_ovf(res_ovf[g])
    );

    // Slice with A1/B1, M, P, OPMODE registers and synchronous reset
    always @(posedge clk) begin
      if (dsp_rst[g]) begin
        a1 <= '0; b1 <= '0; m <= '0; opm_r <= '0; p <= '0; co <= 1'b0;
      end else begin
        a1 <= dsp_a[g];
        b1 <= dsp_b[g];
        m  <= a1 * b1;
        opm_r <= dsp_opmode[g];
        {co, p} <= slice_post(opm_r, p, m);
      end
    end
    assign dsp_p[g]        = p;
    assign dsp_carryout[g] = co;
  end

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Reference: dot product with explicit mod-2^48 wrap and carry detection
  logic [17:0] ra[$];
  logic [17:0] rb[$];
  function automatic logic [48:0] ref_sum();
    longint unsigned acc = 0;
    logic ovf = 1'b0;
    for (int i = 0; i < ra.size(); i++) begin
      acc = acc + longint'(ra[i]) * longint'(rb[i]);
      if (acc >= 64'h1_0000_0000_0000) begin
        ovf = 1'b1;
        acc = acc - 64'h1_0000_0000_0000;
      end
    end
    return {ovf, acc[47:0]};
  endfunction

  task automatic send(input int k, input logic [17:0] a, input logic [17:0] b);
    int t = 0;
    in_valid[k] = 1'b1;
    in_a[k] = a;
    in_b[k] = b;
    while (!in_ready[k] && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", {63'd0, in_ready[k]}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic get_res(input int k, input string nm, input logic [47:0] ed, input logic eo, input int dly);
    int t = 0;
    while (!res_valid[k] && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (dly) @(negedge clk);
    check({nm, "_valid"}, {63'd0, res_valid[k]}, 64'd1);
    check({nm, "_data"}, {16'd0, res_data[k]}, {16'd0, ed});
    check({nm, "_ovf"}, {63'd0, res_ovf[k]}, {63'd0, eo});
    res_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready[k] = 1'b0;
    check({nm, "_valid_drop"}, {63'd0, res_valid[k]}, 64'd0);
  endtask

  task automatic run_frame(input int k, input int nt, input string nm, input bit all_max);
    logic [17:0] a, b;
    logic [48:0] e;
    ra.delete();
    rb.delete();
    for (int j = 0; j < nt; j++) begin
      if (all_max) begin
        a = MAXV; b = MAXV;
      end else begin
        a = ($urandom_range(0, 3) == 0) ? MAXV : 18'($urandom);
        b = ($urandom_range(0, 3) == 0) ? MAXV : 18'($urandom);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      ra.push_back(a);
      rb.push_back(b);
      send(k, a, b);
    end
    e = ref_sum();
    get_res(k, nm, e[47:0], e[48], all_max ? 0 : int'($urandom_range(0, 3)));
  endtask

  typedef struct {
    string       nm;
    int          gap;
    logic [17:0] a [4];
    logic [17:0] b [4];
    logic [47:0] exp_d;
  } vec_t;

  vec_t vt [7];

  function automatic void set_vec(input int i, input string nm, input int gap,
                                  input logic [17:0] a0, input logic [17:0] a1,
                                  input logic [17:0] a2, input logic [17:0] a3,
                                  input logic [17:0] b0, input logic [17:0] b1,
                                  input logic [17:0] b2, input logic [17:0] b3,
                                  input logic [47:0] e);
    vt[i].nm = nm;
    vt[i].gap = gap;
    vt[i].a[0] = a0; vt[i].a[1] = a1; vt[i].a[2] = a2; vt[i].a[3] = a3;
    vt[i].b[0] = b0; vt[i].b[1] = b1; vt[i].b[2] = b2; vt[i].b[3] = b3;
    vt[i].exp_d = e;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    set_vec(0, "seq20",  0, 1, 2, 3, 4, 2, 2, 2, 2, 48'd20);
    set_vec(1, "gap20",  2, 1, 2, 3, 4, 2, 2, 2, 2, 48'd20);
    set_vec(2, "ones",   0, 1, 1, 1, 1, 1, 1, 1, 1, 48'd4);
    set_vec(3, "fives",  1, 5, 5, 5, 5, 5, 5, 5, 5, 48'd100);
    set_vec(4, "max4",   0, MAXV, MAXV, MAXV, MAXV, MAXV, MAXV, MAXV, MAXV, 48'd274875809796);
    set_vec(5, "mixed",  1, 100, 0, 65535, 7, 200, 3, 2, 1, 48'd151077);
    set_vec(6, "zeros",  0, 0, 0, 0, 0, 0, 0, 0, 0, 48'd0);

    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0; in_a[k] = '0; in_b[k] = '0; res_ready[k] = 1'b0;
    end
    #12;
    for (int k = 0; k < NI; k++) begin
      check("rst_in_ready",  {63'd0, in_ready[k]},  64'd0);
      check("rst_dsp_rst",   {63'd0, dsp_rst[k]},   64'd1);
      check("rst_opmode",    {56'd0, dsp_opmode[k]}, 64'h08);
      check("rst_res_valid", {63'd0, res_valid[k]}, 64'd0);
      check("rst_res_data",  {16'd0, res_data[k]},  64'd0);
      check("rst_dsp_a",     {46'd0, dsp_a[k]},     64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_dsp_rst_held", {63'd0, dsp_rst[0]}, 64'd1);
    @(negedge clk);
    check("rel_dsp_rst_low", {63'd0, dsp_rst[0]}, 64'd0);
    check("rel_in_ready",    {63'd0, in_ready[0]}, 64'd1);

    // Gap inside a frame: HOLD codes appear, sum unaffected, 4-edge drain latency
    send(0, 1, 2);  check("gap_op_t0",   {56'd0, dsp_opmode[0]}, 64'h08);
    send(0, 2, 2);  check("gap_op_t1",   {56'd0, dsp_opmode[0]}, 64'h01);
    @(negedge clk); check("gap_op_g0",   {56'd0, dsp_opmode[0]}, 64'h09);
    @(negedge clk); check("gap_op_g1",   {56'd0, dsp_opmode[0]}, 64'h08);
    send(0, 3, 2);  check("gap_op_t2",   {56'd0, dsp_opmode[0]}, 64'h08);
    send(0, 4, 2);  check("gap_op_t3",   {56'd0, dsp_opmode[0]}, 64'h09);
    check("gap_dsp_a", {46'd0, dsp_a[0]}, 64'd4);
    lat = 0;
    while (!res_valid[0] && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("drain_in_ready", {63'd0, in_ready[0]}, 64'd0);
    end
    check("result_latency", 64'(lat), 64'd4);
    get_res(0, "gap_hand", 48'd20, 1'b0, 0);

    // Table-driven frames on the 4-tap instance
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 2) repeat (vt[i].gap) @(negedge clk);
        send(0, vt[i].a[j], vt[i].b[j]);
      end
      get_res(0, vt[i].nm, vt[i].exp_d, 1'b0, i % 3);
    end

    // Result back-pressure across two frames
    for (int j = 0; j < 4; j++) send(0, 1, 1);
    lat = 0;
    while (!res_valid[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_data",  {16'd0, res_data[0]},  64'd4);
      check("bp_hold_valid", {63'd0, res_valid[0]}, 64'd1);
      check("bp_in_ready",   {63'd0, in_ready[0]},  64'd0);
      @(negedge clk);
    end
    get_res(0, "bp_first", 48'd4, 1'b0, 0);
    check("bp_ready_again", {63'd0, in_ready[0]}, 64'd1);
    for (int j = 0; j < 4; j++) send(0, 5, 5);
    get_res(0, "bp_second", 48'd100, 1'b0, 0);

    // Asynchronous reset in mid-frame discards the partial sum
    send(0, 9, 9);
    send(0, 9, 9);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_dsp_rst",   {63'd0, dsp_rst[0]},   64'd1);
    check("mid_rst_in_ready",  {63'd0, in_ready[0]},  64'd0);
    check("mid_rst_opmode",    {56'd0, dsp_opmode[0]}, 64'h08);
    check("mid_rst_dsp_a",     {46'd0, dsp_a[0]},     64'd0);
    check("mid_rst_res_valid", {63'd0, res_valid[0]}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 4; j++) send(0, 3, 3);
    get_res(0, "after_rst", 48'd36, 1'b0, 0);

    // Single-tap instance
    send(1, 7, 9);  check("n1_op0", {56'd0, dsp_opmode[1]}, 64'h08);
    @(negedge clk); check("n1_op1", {56'd0, dsp_opmode[1]}, 64'h01);
    @(negedge clk); check("n1_op2", {56'd0, dsp_opmode[1]}, 64'h08);
    get_res(1, "n1_63", 48'd63, 1'b0, 0);
    for (int r = 0; r < 6; r++) run_frame(1, 1, "n1_rand", 1'b0);

    // Randomized frames on the 4-tap instance
    for (int r = 0; r < 25; r++) run_frame(0, 4, "n4_rand", 1'b0);

    // 4097 full-scale taps wrap the 48-bit accumulator
    run_frame(2, 4097, "n4097_max", 1'b1);
    check("n4097_expect_ovf_data", {16'd0, res_data[2]}, 64'd66571472897);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
